// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// bus widths, FSM encoding, grant identifiers and enable levels.
package mem_port_arbiter_pkg;

   localparam int MemDataWidth  = 32;
   localparam int MemAddrWidth  = 32;
   localparam int ByteSlctWidth = MemDataWidth / 8;

   // Wait counter covers 0..15 extra memory cycles.
   localparam int WaitCntWidth  = 4;

   localparam logic ChipEnable  = 1'b1;
   localparam logic WriteEnable = 1'b1;
   localparam logic RstEnable   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } grant_e;

   // Terminal count of the wait counter for a given number of extra cycles.
   function automatic logic [WaitCntWidth-1:0] wait_last(input int cycles);
      return WaitCntWidth'(cycles);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory pins seen by the arbiter.
// The slave modport is the arbiter view; master is the core + memory view.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = MemAddrWidth,
   parameter int DATA_W = MemDataWidth,
   parameter int BSEL_W = ByteSlctWidth
) ();

   // fetch port
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_ack_o;
   logic              if_stall_o;

   // data port
   logic              d_req_i;
   logic              d_we_i;
   logic [ADDR_W-1:0] d_addr_i;
   logic [DATA_W-1:0] d_wdata_i;
   logic [BSEL_W-1:0] d_bsel_i;
   logic [DATA_W-1:0] d_rdata_o;
   logic              d_ack_o;
   logic              d_stall_o;

   // memory pins
   logic              mem_ce_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic [BSEL_W-1:0] mem_bsel_o;
   logic [DATA_W-1:0] mem_data_i;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_rdata_o, if_ack_o, if_stall_o,
      input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_bsel_i,
      output d_rdata_o, d_ack_o, d_stall_o,
      output mem_ce_o, mem_we_o, mem_addr_o, mem_data_o, mem_bsel_o,
      input  mem_data_i
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_rdata_o, if_ack_o, if_stall_o,
      output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_bsel_i,
      input  d_rdata_o, d_ack_o, d_stall_o,
      input  mem_ce_o, mem_we_o, mem_addr_o, mem_data_o, mem_bsel_o,
      output mem_data_i
   );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-requester round-robin picker. Bit 0 of req_i is the IF requester,
// bit 1 the data requester. With no request the output is don't-care
// (reports GNT_D); the caller qualifies it with |req_i.
module rr_pick2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  grant_e     last_grant_i,
   output grant_e     grant_o
);

   // IF wins when it asks alone, or on a tie when data had the last turn.
   always_comb begin
      grant_o = GNT_D;
      if (req_i[0] && (!req_i[1] || (last_grant_i == GNT_D))) begin
         grant_o = GNT_IF;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One transaction at a time: grant in IDLE, drive the memory for
// WAIT_CYCLES+1 cycles in ACCESS, pulse ack in RESP.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | no access in flight; requests sampled and arbitrated
//   ST_ACCESS | memory pins driven from latched request, wait counter runs
//   ST_RESP   | one-cycle ack to the granted port; requests not sampled
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 0,
   parameter int ADDR_W      = MemAddrWidth,
   parameter int DATA_W      = MemDataWidth,
   parameter int BSEL_W      = ByteSlctWidth
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam logic [WaitCntWidth-1:0] WaitLast = wait_last(WAIT_CYCLES);

   arb_state_e              state_q;
   logic [WaitCntWidth-1:0] cnt_q;
   logic [WaitCntWidth-1:0] cnt_d;
   grant_e                  gnt_q;
   grant_e                  last_grant_q;
   grant_e                  grant_d;
   logic [1:0]              req_d;

   // The mem_* registers double as the latched request: they are loaded
   // at grant and cleared when leaving ACCESS, so they read 0 elsewhere.
   logic                    mem_ce_q;
   logic                    mem_we_q;
   logic [ADDR_W-1:0]       mem_addr_q;
   logic [DATA_W-1:0]       mem_data_q;
   logic [BSEL_W-1:0]       mem_bsel_q;

   logic [DATA_W-1:0]       if_rdata_q;
   logic [DATA_W-1:0]       d_rdata_q;
   logic                    if_ack_q;
   logic                    d_ack_q;

   assign req_d = {bus.d_req_i, bus.if_req_i};
   assign cnt_d = cnt_q + 1'b1;

   rr_pick2 u_pick (
      .req_i        (req_d),
      .last_grant_i (last_grant_q),
      .grant_o      (grant_d)
   );

   // Arbitration, access sequencing, read capture and ack generation.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         gnt_q        <= GNT_IF;
         last_grant_q <= GNT_IF;
         mem_ce_q     <= ~ChipEnable;
         mem_we_q     <= ~WriteEnable;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_bsel_q   <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         if_ack_q     <= 1'b0;
         d_ack_q      <= 1'b0;
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|req_d) begin
                  state_q      <= ST_ACCESS;
                  cnt_q        <= '0;
                  gnt_q        <= grant_d;
                  last_grant_q <= grant_d;
                  mem_ce_q     <= ChipEnable;
                  if (grant_d == GNT_IF) begin
                     // fetches are reads with no lanes and no write data
                     mem_we_q   <= ~WriteEnable;
                     mem_addr_q <= bus.if_addr_i;
                     mem_data_q <= '0;
                     mem_bsel_q <= '0;
                  end else begin
                     mem_we_q   <= bus.d_we_i;
                     mem_addr_q <= bus.d_addr_i;
                     mem_data_q <= bus.d_wdata_i;
                     mem_bsel_q <= bus.d_bsel_i;
                  end
               end
            end
            ST_ACCESS: begin
               if (cnt_q == WaitLast) begin
                  if (gnt_q == GNT_IF) begin
                     if_rdata_q <= bus.mem_data_i;
                     if_ack_q   <= 1'b1;
                  end else begin
                     if (mem_we_q != WriteEnable) begin
                        d_rdata_q <= bus.mem_data_i;
                     end
                     d_ack_q <= 1'b1;
                  end
                  state_q    <= ST_RESP;
                  cnt_q      <= '0;
                  mem_ce_q   <= ~ChipEnable;
                  mem_we_q   <= ~WriteEnable;
                  mem_addr_q <= '0;
                  mem_data_q <= '0;
                  mem_bsel_q <= '0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_ce_o   = mem_ce_q;
   assign bus.mem_we_o   = mem_we_q;
   assign bus.mem_addr_o = mem_addr_q;
   assign bus.mem_data_o = mem_data_q;
   assign bus.mem_bsel_o = mem_bsel_q;

   assign bus.if_rdata_o = if_rdata_q;
   assign bus.if_ack_o   = if_ack_q;
   assign bus.d_rdata_o  = d_rdata_q;
   assign bus.d_ack_o    = d_ack_q;

   // Stalls follow req/ack directly so the pipeline sees them the same cycle.
   assign bus.if_stall_o = bus.if_req_i & ~if_ack_q;
   assign bus.d_stall_o  = bus.d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with no wait states,
// one with three, each backed by a small behavioural word memory.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst0;
   logic rst3;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if b0 ();
   mem_port_arbiter_if b3 ();

   mem_port_arbiter #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst0), .bus(b0));
   mem_port_arbiter #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(b3));

   logic [31:0] mem0 [0:63] = '{5: 32'h1234_5678, 20: 32'h1122_3344, default: 32'h0};
   logic [31:0] mem3 [0:63] = '{1: 32'h0101_0101, 2: 32'hCAFE_F00D, 3: 32'h0BAD_BEEF, default: 32'h0};

   assign b0.mem_data_i = mem0[b0.mem_addr_o[7:2]];
   assign b3.mem_data_i = mem3[b3.mem_addr_o[7:2]];

   always @(posedge clk) begin
      if (b0.mem_ce_o && b0.mem_we_o)
         for (int i = 0; i < 4; i++)
            if (b0.mem_bsel_o[i]) mem0[b0.mem_addr_o[7:2]][8*i +: 8] <= b0.mem_data_o[8*i +: 8];
   end

   always @(posedge clk) begin
      if (b3.mem_ce_o && b3.mem_we_o)
         for (int i = 0; i < 4; i++)
            if (b3.mem_bsel_o[i]) mem3[b3.mem_addr_o[7:2]][8*i +: 8] <= b3.mem_data_o[8*i +: 8];
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic test_reset;
      rst0 = 1'b1;
      rst3 = 1'b1;
      step();
      step();
      settle();
      n_checks++; if (b0.mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %b want 0", b0.mem_ce_o); end
      n_checks++; if (b0.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", b0.mem_we_o); end
      n_checks++; if (b0.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", b0.mem_addr_o); end
      n_checks++; if (b0.mem_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", b0.mem_data_o); end
      n_checks++; if (b0.mem_bsel_o !== 4'h0) begin n_fail++; $display("FAIL rst_bsel: got %h want 0", b0.mem_bsel_o); end
      n_checks++; if ({b0.if_ack_o, b0.d_ack_o} !== 2'b00) begin n_fail++; $display("FAIL rst_acks: got %b want 00", {b0.if_ack_o, b0.d_ack_o}); end
      n_checks++; if (b0.if_rdata_o !== 32'h0 || b0.d_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h/%h want 0/0", b0.if_rdata_o, b0.d_rdata_o); end
      n_checks++; if ({b0.if_stall_o, b0.d_stall_o} !== 2'b00) begin n_fail++; $display("FAIL rst_stall_noreq: got %b want 00", {b0.if_stall_o, b0.d_stall_o}); end
      b0.if_req_i = 1'b1;
      settle();
      n_checks++; if (b0.if_stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_stall_req: got %b want 1", b0.if_stall_o); end
      n_checks++; if (b3.mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL rst_ce_w3: got %b want 0", b3.mem_ce_o); end
      b0.if_req_i = 1'b0;
      rst0 = 1'b0;
      rst3 = 1'b0;
      step();
      settle();
      n_checks++; if (b0.mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL idle_noreq_ce: got %b want 0", b0.mem_ce_o); end
   endtask

   task automatic test_fetch;
      step();
      b0.if_req_i  = 1'b1;
      b0.if_addr_i = 32'h14;
      settle();
      n_checks++; if (b0.if_stall_o !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0: got %b want 1", b0.if_stall_o); end
      n_checks++; if (b0.mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL fetch_ce_c0: got %b want 0", b0.mem_ce_o); end
      step(); settle();
      n_checks++; if (b0.mem_ce_o !== 1'b1) begin n_fail++; $display("FAIL fetch_ce_c1: got %b want 1", b0.mem_ce_o); end
      n_checks++; if (b0.mem_addr_o !== 32'h14) begin n_fail++; $display("FAIL fetch_addr_c1: got %h want 14", b0.mem_addr_o); end
      n_checks++; if (b0.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL fetch_we_c1: got %b want 0", b0.mem_we_o); end
      n_checks++; if (b0.if_stall_o !== 1'b1 || b0.if_ack_o !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_c1: got stall %b ack %b want 1 0", b0.if_stall_o, b0.if_ack_o); end
      step(); settle();
      n_checks++; if (b0.mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL fetch_ce_c2: got %b want 0", b0.mem_ce_o); end
      n_checks++; if (b0.if_ack_o !== 1'b1) begin n_fail++; $display("FAIL fetch_ack_c2: got %b want 1", b0.if_ack_o); end
      n_checks++; if (b0.if_rdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL fetch_rdata: got %h want 12345678", b0.if_rdata_o); end
      n_checks++; if (b0.if_stall_o !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_c2: got %b want 0", b0.if_stall_o); end
      b0.if_req_i = 1'b0;
      step(); settle();
      n_checks++; if (b0.if_ack_o !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_c3: got %b want 0", b0.if_ack_o); end
      n_checks++; if (b0.if_rdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL fetch_rdata_hold: got %h want 12345678", b0.if_rdata_o); end
   endtask

   task automatic test_store_load;
      step();
      b0.d_req_i   = 1'b1;
      b0.d_we_i    = 1'b1;
      b0.d_addr_i  = 32'h50;
      b0.d_wdata_i = 32'hAABB_CCDD;
      b0.d_bsel_i  = 4'b0011;
      settle();
      n_checks++; if (b0.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL store_we_c0: got %b want 0", b0.mem_we_o); end
      step(); settle();
      n_checks++; if ({b0.mem_ce_o, b0.mem_we_o} !== 2'b11) begin n_fail++; $display("FAIL store_ce_we_c1: got %b want 11", {b0.mem_ce_o, b0.mem_we_o}); end
      n_checks++; if (b0.mem_bsel_o !== 4'b0011) begin n_fail++; $display("FAIL store_bsel_c1: got %b want 0011", b0.mem_bsel_o); end
      n_checks++; if (b0.mem_data_o !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL store_data_c1: got %h want aabbccdd", b0.mem_data_o); end
      n_checks++; if (b0.mem_addr_o !== 32'h50) begin n_fail++; $display("FAIL store_addr_c1: got %h want 50", b0.mem_addr_o); end
      step(); settle();
      n_checks++; if (b0.d_ack_o !== 1'b1) begin n_fail++; $display("FAIL store_ack_c2: got %b want 1", b0.d_ack_o); end
      n_checks++; if ({b0.mem_we_o, b0.mem_bsel_o} !== 5'b0) begin n_fail++; $display("FAIL store_we_bsel_c2: got %b want 00000", {b0.mem_we_o, b0.mem_bsel_o}); end
      n_checks++; if (b0.d_rdata_o !== 32'h0) begin n_fail++; $display("FAIL store_rdata_kept: got %h want 0", b0.d_rdata_o); end
      b0.d_req_i = 1'b0;
      step();
      b0.d_req_i   = 1'b1;
      b0.d_we_i    = 1'b0;
      b0.d_wdata_i = 32'h0;
      b0.d_bsel_i  = 4'b0000;
      settle();
      step(); settle();
      n_checks++; if ({b0.mem_ce_o, b0.mem_we_o} !== 2'b10) begin n_fail++; $display("FAIL load_ce_we_c1: got %b want 10", {b0.mem_ce_o, b0.mem_we_o}); end
      step(); settle();
      n_checks++; if (b0.d_ack_o !== 1'b1) begin n_fail++; $display("FAIL load_ack_c2: got %b want 1", b0.d_ack_o); end
      n_checks++; if (b0.d_rdata_o !== 32'h1122_CCDD) begin n_fail++; $display("FAIL load_merged: got %h want 1122ccdd", b0.d_rdata_o); end
      b0.d_req_i = 1'b0;
   endtask

   task automatic test_round_robin;
      logic exp_if;
      logic exp_d;
      logic d_turn;
      step();
      rst0 = 1'b1;
      step();
      b0.if_req_i  = 1'b1;
      b0.if_addr_i = 32'h14;
      b0.d_req_i   = 1'b1;
      b0.d_we_i    = 1'b0;
      b0.d_addr_i  = 32'h50;
      rst0 = 1'b0;
      settle();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) begin step(); settle(); end
         d_turn = ((c / 3) % 2) == 0;
         exp_d  = (c % 3 == 2) && d_turn;
         exp_if = (c % 3 == 2) && !d_turn;
         n_checks++;
         if ({b0.if_ack_o, b0.d_ack_o} !== {exp_if, exp_d}) begin
            n_fail++; $display("FAIL rr_acks c%0d: got if/d %b want %b", c, {b0.if_ack_o, b0.d_ack_o}, {exp_if, exp_d});
         end
         if (c % 3 == 1) begin
            n_checks++;
            if (b0.mem_addr_o !== (d_turn ? 32'h50 : 32'h14)) begin
               n_fail++; $display("FAIL rr_addr c%0d: got %h want %h", c, b0.mem_addr_o, d_turn ? 32'h50 : 32'h14);
            end
         end
         if (exp_d) begin
            n_checks++;
            if (b0.d_rdata_o !== 32'h1122_CCDD) begin n_fail++; $display("FAIL rr_d_rdata c%0d: got %h want 1122ccdd", c, b0.d_rdata_o); end
         end
         if (exp_if) begin
            n_checks++;
            if (b0.if_rdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL rr_if_rdata c%0d: got %h want 12345678", c, b0.if_rdata_o); end
         end
      end
      b0.if_req_i = 1'b0;
      b0.d_req_i  = 1'b0;
   endtask

   task automatic test_drop;
      int acks;
      int ce_late;
      acks    = 0;
      ce_late = 0;
      step();
      b0.d_req_i  = 1'b1;
      b0.d_we_i   = 1'b0;
      b0.d_addr_i = 32'h14;
      settle();
      step();
      b0.d_req_i = 1'b0;
      settle();
      n_checks++; if (b0.mem_ce_o !== 1'b1) begin n_fail++; $display("FAIL drop_ce_c1: got %b want 1", b0.mem_ce_o); end
      for (int c = 2; c <= 8; c++) begin
         step(); settle();
         if (b0.d_ack_o === 1'b1 || b0.if_ack_o === 1'b1) acks++;
         if (c >= 3 && b0.mem_ce_o !== 1'b0) ce_late++;
         if (c == 2) begin
            n_checks++; if (b0.d_ack_o !== 1'b1) begin n_fail++; $display("FAIL drop_ack_c2: got %b want 1", b0.d_ack_o); end
            n_checks++; if (b0.d_rdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL drop_rdata: got %h want 12345678", b0.d_rdata_o); end
         end
      end
      n_checks++; if (acks != 1) begin n_fail++; $display("FAIL drop_ack_count: got %0d want 1", acks); end
      n_checks++; if (ce_late != 0) begin n_fail++; $display("FAIL drop_regrant: got %0d ce cycles want 0", ce_late); end
   endtask

   task automatic test_wait_states;
      logic exp_ce;
      logic exp_ack;
      step();
      b3.d_req_i  = 1'b1;
      b3.d_we_i   = 1'b0;
      b3.d_addr_i = 32'h08;
      settle();
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) begin step(); settle(); end
         exp_ce  = (c >= 1) && (c <= 4);
         exp_ack = (c == 5);
         n_checks++; if (b3.mem_ce_o !== exp_ce) begin n_fail++; $display("FAIL w3_ce c%0d: got %b want %b", c, b3.mem_ce_o, exp_ce); end
         n_checks++; if (b3.d_ack_o !== exp_ack) begin n_fail++; $display("FAIL w3_ack c%0d: got %b want %b", c, b3.d_ack_o, exp_ack); end
         if (c == 5) begin
            n_checks++; if (b3.d_rdata_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL w3_rdata: got %h want cafef00d", b3.d_rdata_o); end
            b3.d_req_i = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid;
      int acks;
      acks = 0;
      step();
      b3.d_req_i  = 1'b1;
      b3.d_we_i   = 1'b0;
      b3.d_addr_i = 32'h0C;
      settle();
      step(); settle();
      step(); settle();
      n_checks++; if (b3.mem_ce_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ce_c2: got %b want 1", b3.mem_ce_o); end
      rst3 = 1'b1;
      b3.d_req_i = 1'b0;
      step(); settle();
      n_checks++;
      if ({b3.mem_ce_o, b3.mem_we_o, b3.mem_bsel_o} !== 6'b0 || b3.mem_addr_o !== 32'h0 || b3.mem_data_o !== 32'h0) begin
         n_fail++; $display("FAIL rmid_mem_zero: got ce %b we %b addr %h data %h bsel %h want all 0",
                            b3.mem_ce_o, b3.mem_we_o, b3.mem_addr_o, b3.mem_data_o, b3.mem_bsel_o);
      end
      n_checks++; if (b3.d_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rmid_rdata_clr: got %h want 0", b3.d_rdata_o); end
      if (b3.d_ack_o === 1'b1) acks++;
      step();
      rst3 = 1'b0;
      settle();
      for (int c = 0; c < 8; c++) begin
         step(); settle();
         if (b3.d_ack_o === 1'b1 || b3.if_ack_o === 1'b1) acks++;
      end
      n_checks++; if (acks != 0) begin n_fail++; $display("FAIL rmid_no_ack: got %0d acks want 0", acks); end
      b3.if_req_i  = 1'b1;
      b3.if_addr_i = 32'h04;
      b3.d_req_i   = 1'b1;
      b3.d_we_i    = 1'b0;
      b3.d_addr_i  = 32'h08;
      settle();
      for (int c = 1; c <= 5; c++) begin
         step(); settle();
         if (c == 1) begin
            n_checks++; if (b3.mem_addr_o !== 32'h08) begin n_fail++; $display("FAIL rmid_tie_addr: got %h want 08", b3.mem_addr_o); end
         end
         if (c == 5) begin
            n_checks++; if ({b3.if_ack_o, b3.d_ack_o} !== 2'b01) begin n_fail++; $display("FAIL rmid_tie_ack: got if/d %b want 01", {b3.if_ack_o, b3.d_ack_o}); end
         end
      end
      b3.if_req_i = 1'b0;
      b3.d_req_i  = 1'b0;
   endtask

   initial begin
      rst0 = 1'b1;
      rst3 = 1'b1;
      b0.if_req_i = 1'b0; b0.if_addr_i = '0;
      b0.d_req_i = 1'b0; b0.d_we_i = 1'b0; b0.d_addr_i = '0; b0.d_wdata_i = '0; b0.d_bsel_i = '0;
      b3.if_req_i = 1'b0; b3.if_addr_i = '0;
      b3.d_req_i = 1'b0; b3.d_we_i = 1'b0; b3.d_addr_i = '0; b3.d_wdata_i = '0; b3.d_bsel_i = '0;
      test_reset();
      test_fetch();
      test_store_load();
      test_round_robin();
      test_drop();
      test_wait_states();
      test_reset_mid();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the end of the sequence");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port behavioural data/instruction memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store with byte select).
- Serialises accesses through a small FSM, inserts a parameterised number of wait cycles to model slow memory, and registers read data.
- Returns a one-cycle ack per transaction; drives per-port stall outputs for the pipeline controller.
- Sits between the CPU core and the memory's ce/we/addr/data/byte_slct pins.

Parameters:
- WAIT_CYCLES, 0, extra memory-access cycles per transaction (0..15).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- BSEL_W, 4, byte-select width (DATA_W/8).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- if_req_i  in  1  fetch request; held until if_ack_o
- if_addr_i  in  ADDR_W  fetch byte address
- if_rdata_o  out  DATA_W  fetched word; valid while if_ack_o=1
- if_ack_o  out  1  one-cycle completion pulse
- if_stall_o  out  1  if_req_i & ~if_ack_o (combinational)
- d_req_i  in  1  data request; held until d_ack_o
- d_we_i  in  1  1=store, 0=load
- d_addr_i  in  ADDR_W  data byte address
- d_wdata_i  in  DATA_W  store data
- d_bsel_i  in  BSEL_W  store byte lanes
- d_rdata_o  out  DATA_W  load word; valid while d_ack_o=1
- d_ack_o  out  1  one-cycle completion pulse
- d_stall_o  out  1  d_req_i & ~d_ack_o (combinational)
- mem_ce_o  out  1  memory chip enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- mem_bsel_o  out  BSEL_W  memory byte select
- mem_data_i  in  DATA_W  memory read data (combinational from memory)

Behaviour:
- States:
  - IDLE: no access in flight.
  - ACCESS: memory pins driven; wait counter runs.
  - RESP: ack pulse to the granted port.
- IDLE transitions:
  - No request: stay IDLE.
  - Any request: latch grant, address, we, wdata, bsel into internal registers; go to ACCESS; wait counter := 0.
- ACCESS:
  - mem_ce_o=1; mem_addr_o, mem_we_o, mem_data_o, mem_bsel_o come from the latched registers.
  - Fetch grant forces mem_we_o=0, mem_bsel_o=0, mem_data_o=0.
  - Stay while counter < WAIT_CYCLES, incrementing by 1 each cycle.
  - On the cycle where counter == WAIT_CYCLES: capture mem_data_i into the granted port's rdata register (loads/fetches only; stores leave rdata unchanged); go to RESP.
- RESP:
  - Assert the granted port's ack for exactly one cycle; mem_ce_o=0, mem_we_o=0; return to IDLE.
  - A new request is not sampled in RESP.
  - The same requester re-issuing gets its next grant at the earliest in the following IDLE cycle.
- Latency: request sampled at IDLE edge k -> ack high in cycle k+2+WAIT_CYCLES. Back-to-back throughput is one transaction per 3+WAIT_CYCLES cycles.
- Arbitration (both requests seen in IDLE):
  - Two-way round robin on a last_grant register.
  - last_grant=DATA and if_req_i=1 -> grant IF; otherwise grant DATA.
  - A single requester is always granted.
  - last_grant updates on every grant.
- Idle outputs: whenever not in ACCESS, all mem_* outputs are 0.
- rdata registers hold their value between acks.
- Inputs are sampled only at grant; changes during ACCESS/RESP are ignored.
- Request dropped mid-transaction: the access still completes and ack still pulses. Requesters must hold req until ack.
- Reset, including mid-transaction: state=IDLE, counter=0, last_grant=IF (so DATA wins the first tie), both rdata=0, both acks=0, all mem_* outputs=0.
  - A store aborted by reset leaves memory unspecified for that word.
- Stall outputs: purely combinational from req/ack, so they are 0 during reset whenever req=0.

Decomposition:
- Shared package/define file holds:
  - width constants (MemDataWidth, MemAddrWidth, ByteSlctWidth);
  - FSM state encoding (IDLE/ACCESS/RESP, 2 bits);
  - grant IDs (GNT_IF=0, GNT_D=1);
  - enable-level constants (ChipEnable, WriteEnable, RstEnable).
- One sub-module, rr_pick2: two-request round-robin picker (inputs req[1:0] and last_grant, output grant), reused later for cache refill arbitration.

Test Plan:
- WAIT_CYCLES=0, memory word 5 = 0x1234_5678, if_req_i at cycle 0 with addr 0x14 -> mem_ce_o high in cycle 1 only; if_ack_o in cycle 2 with if_rdata_o=0x1234_5678; if_stall_o high in cycles 0-1.
- Store d_addr 0x50, wdata 0xAABB_CCDD, bsel 4'b0011 over old 0x1122_3344 -> load at 0x50 returns 0x1122_CCDD; during the store mem_bsel_o=4'b0011 and mem_we_o=1 only in ACCESS.
- if_req_i and d_req_i held together from reset release -> grants alternate D, IF, D, IF; each ack occurs 3 cycles apart (WAIT_CYCLES=0).
- WAIT_CYCLES=3, single load -> mem_ce_o high for exactly 4 cycles; d_ack_o high 5 cycles after the request is sampled.
- rst asserted on the second ACCESS cycle (WAIT_CYCLES=3) -> next cycle all mem_* outputs=0, no ack ever issued; a subsequent tie goes to DATA.
- d_req_i deasserted one cycle after grant -> access completes and d_ack_o still pulses once; no further grant is issued.
